fft_output_unloader: RTL and testbench

- Terminal block of the 1024-point CORDIC FFT pipeline; sits after stage_10.
- Accepts one butterfly output pair per cycle and undoes bit-reversed ordering via a ping-pong buffer.
- Emits one complex bin per cycle in natural order (bin 0..1023) to a downstream consumer.
- Uses a valid/ready handshake with backpressure on the output side.

---
 rtl/fft_pkg.sv | 31 +++
 rtl/dual_port_ram.sv | 32 +++
 rtl/out_skid_buf.sv | 68 ++++++
 rtl/fft_output_unloader.sv | 173 +++++++++++++++++
 tb/tb_fft_output_unloader.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================
// Package : fft_pkg
// Brief   : shared sizes, bank-state encoding and bit-reverse helper
// Rev     : 1.0  initial release
// ============================================================
package fft_pkg;

    localparam int N      = 1024;
    localparam int DATA_W = 32;
    localparam int PAIR_W = 9;
    localparam int BIN_W  = 10;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } bank_state_t;

    function automatic logic [PAIR_W-1:0] bitrev(input logic [PAIR_W-1:0] v);
        logic [PAIR_W-1:0] r;
        r = '0;
        for (int i = 0; i < PAIR_W; i++) begin
            r[i] = v[PAIR_W-1-i];
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dual_port_ram.sv
`default_nettype none
// ============================================================
// Module : dual_port_ram
// Brief  : true dual-port synchronous RAM, one-cycle read latency
// Rev    : 1.0  initial release
// ============================================================
module dual_port_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
) (
    input  logic              i_clk,
    input  logic              i_we_a,
    input  logic [ADDR_W-1:0] i_addr_a,
    input  logic [DATA_W-1:0] i_din_a,
    output logic [DATA_W-1:0] o_dout_a,
    input  logic              i_we_b,
    input  logic [ADDR_W-1:0] i_addr_b,
    input  logic [DATA_W-1:0] i_din_b,
    output logic [DATA_W-1:0] o_dout_b
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    always_ff @(posedge i_clk) begin
        if (i_we_a) r_mem[i_addr_a] <= i_din_a;
        if (i_we_b) r_mem[i_addr_b] <= i_din_b;
        o_dout_a <= r_mem[i_addr_a];
        o_dout_b <= r_mem[i_addr_b];
    end

endmodule
`default_nettype wire

// File: rtl/out_skid_buf.sv
`default_nettype none
// ============================================================
// Module : out_skid_buf
// Brief  : 2-entry valid/ready output buffer; producer must respect o_count
// Rev    : 1.0  initial release
// ============================================================
module out_skid_buf #(
    parameter int WIDTH = 75
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic [1:0]       o_count
);

    logic             r_v0, r_v1;
    logic [WIDTH-1:0] r_d0, r_d1;
    logic             w_pop;

    always_comb begin
        w_pop   = r_v0 && i_ready;
        o_valid = r_v0;
        o_data  = r_d0;
        o_count = {1'b0, r_v0} + {1'b0, r_v1};
    end

    // Head entry r_d0 is the only one visible; it only changes on a pop.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_v0 <= 1'b0;
            r_v1 <= 1'b0;
            r_d0 <= '0;
            r_d1 <= '0;
        end else begin
            case ({w_pop, i_push})
                2'b01: begin
                    if (!r_v0) begin
                        r_v0 <= 1'b1;
                        r_d0 <= i_data;
                    end else begin
                        r_v1 <= 1'b1;
                        r_d1 <= i_data;
                    end
                end
                2'b10: begin
                    r_v0 <= r_v1;
                    r_d0 <= r_d1;
                    r_v1 <= 1'b0;
                end
                2'b11: begin
                    if (r_v1) begin
                        r_d0 <= r_d1;
                        r_d1 <= i_data;
                    end else begin
                        r_d0 <= i_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/fft_output_unloader.sv
`default_nettype none
// ============================================================
// Module : fft_output_unloader
// Brief  : bit-reversed butterfly pairs in, natural-order bins out via ping-pong banks
// Rev    : 1.0  initial release
// ============================================================
module fft_output_unloader #(
    parameter int DATA_W = fft_pkg::DATA_W,
    parameter int N      = fft_pkg::N,
    parameter int PAIR_W = fft_pkg::PAIR_W
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_valid_in,
    input  logic [DATA_W-1:0]        i_data_a_real,
    input  logic [DATA_W-1:0]        i_data_a_imag,
    input  logic [DATA_W-1:0]        i_data_b_real,
    input  logic [DATA_W-1:0]        i_data_b_imag,
    input  logic                     i_ready,
    output logic                     o_valid_out,
    output logic [DATA_W-1:0]        o_data_real,
    output logic [DATA_W-1:0]        o_data_imag,
    output logic [fft_pkg::BIN_W-1:0] o_bin_idx,
    output logic                     o_last,
    output logic                     o_overflow
);

    import fft_pkg::*;

    localparam int ADDR_W = PAIR_W + 1;
    localparam int SKID_W = 2 * DATA_W + BIN_W + 1;
    localparam logic [PAIR_W-1:0] C_LAST_PAIR = PAIR_W'(N / 2 - 1);
    localparam logic [BIN_W-1:0]  C_LAST_BIN  = BIN_W'(N - 1);

    bank_state_t       r_bank_state [2];
    logic              r_wr_bank, r_rd_bank, r_iss_bank, r_iss_active;
    logic [PAIR_W-1:0] r_pair_cnt;
    logic [BIN_W-1:0]  r_rd_cnt;
    logic              r_overflow;
    logic              r_pend, r_pend_bank, r_pend_sel, r_pend_last;
    logic [BIN_W-1:0]  r_pend_idx;

    logic              w_wr_ok, w_pop, w_accept_last, w_can_issue, w_iss_start, w_issue;
    logic [1:0]        w_skid_cnt, w_load;
    logic [ADDR_W-1:0] w_wr_addr, w_rd_addr;
    logic [DATA_W-1:0] w_rd_a_re [2];
    logic [DATA_W-1:0] w_rd_a_im [2];
    logic [DATA_W-1:0] w_rd_b_re [2];
    logic [DATA_W-1:0] w_rd_b_im [2];
    logic [DATA_W-1:0] w_sel_re, w_sel_im;
    logic              w_out_valid, w_out_last;
    logic [SKID_W-1:0] w_skid_out;

    always_comb begin
        w_wr_ok       = i_valid_in && (r_bank_state[r_wr_bank] == EMPTY ||
                                       r_bank_state[r_wr_bank] == FILLING);
        w_wr_addr     = {1'b0, bitrev(r_pair_cnt)};
        w_pop         = w_out_valid && i_ready;
        w_accept_last = w_pop && w_out_last;
        // RAM data in flight counts against skid space.
        w_load        = w_skid_cnt + {1'b0, r_pend};
        w_can_issue   = (w_load < 2'd2) || (w_load == 2'd2 && w_pop);
        w_iss_start   = !r_iss_active && r_bank_state[r_iss_bank] == FULL;
        w_issue       = (r_iss_active || w_iss_start) && w_can_issue;
        w_rd_addr     = {1'b0, r_rd_cnt[BIN_W-1:1]};
        w_sel_re      = r_pend_sel ? w_rd_b_re[r_pend_bank] : w_rd_a_re[r_pend_bank];
        w_sel_im      = r_pend_sel ? w_rd_b_im[r_pend_bank] : w_rd_a_im[r_pend_bank];
    end

    // The issue pointer runs ahead of rd_bank so the next FULL bank can
    // start filling the skid before the current frame's last bin is taken.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            for (int b = 0; b < 2; b++) begin
                r_bank_state[b] <= EMPTY;
            end
            r_wr_bank    <= 1'b0;
            r_rd_bank    <= 1'b0;
            r_iss_bank   <= 1'b0;
            r_iss_active <= 1'b0;
            r_pair_cnt   <= '0;
            r_rd_cnt     <= '0;
            r_overflow   <= 1'b0;
            r_pend       <= 1'b0;
            r_pend_bank  <= 1'b0;
            r_pend_sel   <= 1'b0;
            r_pend_last  <= 1'b0;
            r_pend_idx   <= '0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (w_wr_ok && r_wr_bank == 1'(b)) begin
                    r_bank_state[b] <= (r_pair_cnt == C_LAST_PAIR) ? FULL : FILLING;
                end else if (w_issue && w_iss_start && r_iss_bank == 1'(b)) begin
                    r_bank_state[b] <= DRAINING;
                end else if (w_accept_last && r_rd_bank == 1'(b)) begin
                    r_bank_state[b] <= EMPTY;
                end
            end

            if (w_wr_ok) begin
                r_pair_cnt <= r_pair_cnt + PAIR_W'(1);
                if (r_pair_cnt == C_LAST_PAIR) r_wr_bank <= ~r_wr_bank;
            end else if (i_valid_in) begin
                r_overflow <= 1'b1;
            end

            r_pend <= w_issue;
            if (w_issue) begin
                r_pend_bank <= r_iss_bank;
                r_pend_sel  <= r_rd_cnt[0];
                r_pend_idx  <= r_rd_cnt;
                r_pend_last <= (r_rd_cnt == C_LAST_BIN);
                r_rd_cnt    <= r_rd_cnt + BIN_W'(1);
                if (r_rd_cnt == C_LAST_BIN) begin
                    r_iss_active <= 1'b0;
                    r_iss_bank   <= ~r_iss_bank;
                end else begin
                    r_iss_active <= 1'b1;
                end
            end

            if (w_accept_last) r_rd_bank <= ~r_rd_bank;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        logic              w_we;
        logic [DATA_W-1:0] w_unused_are, w_unused_aim, w_unused_bre, w_unused_bim;

        assign w_we = w_wr_ok && (r_wr_bank == 1'(b));

        dual_port_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram_a_re (
            .i_clk(i_clk), .i_we_a(1'b0), .i_addr_a(w_rd_addr), .i_din_a('0),
            .o_dout_a(w_rd_a_re[b]), .i_we_b(w_we), .i_addr_b(w_wr_addr),
            .i_din_b(i_data_a_real), .o_dout_b(w_unused_are)
        );
        dual_port_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram_a_im (
            .i_clk(i_clk), .i_we_a(1'b0), .i_addr_a(w_rd_addr), .i_din_a('0),
            .o_dout_a(w_rd_a_im[b]), .i_we_b(w_we), .i_addr_b(w_wr_addr),
            .i_din_b(i_data_a_imag), .o_dout_b(w_unused_aim)
        );
        dual_port_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram_b_re (
            .i_clk(i_clk), .i_we_a(1'b0), .i_addr_a(w_rd_addr), .i_din_a('0),
            .o_dout_a(w_rd_b_re[b]), .i_we_b(w_we), .i_addr_b(w_wr_addr),
            .i_din_b(i_data_b_real), .o_dout_b(w_unused_bre)
        );
        dual_port_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram_b_im (
            .i_clk(i_clk), .i_we_a(1'b0), .i_addr_a(w_rd_addr), .i_din_a('0),
            .o_dout_a(w_rd_b_im[b]), .i_we_b(w_we), .i_addr_b(w_wr_addr),
            .i_din_b(i_data_b_imag), .o_dout_b(w_unused_bim)
        );
    end

    out_skid_buf #(.WIDTH(SKID_W)) u_skid (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (r_pend),
        .i_data  ({w_sel_re, w_sel_im, r_pend_idx, r_pend_last}),
        .i_ready (i_ready),
        .o_valid (w_out_valid),
        .o_data  (w_skid_out),
        .o_count (w_skid_cnt)
    );

    always_comb begin
        o_valid_out = w_out_valid;
        {o_data_real, o_data_imag, o_bin_idx, w_out_last} = w_skid_out;
        o_last      = w_out_last;
        o_overflow  = r_overflow;
    end

endmodule
`default_nettype wire

// File: tb/tb_fft_output_unloader.sv
`default_nettype none
// ============================================================
// Module : tb_fft_output_unloader
// Brief  : randomized self-checking bench against a frame-level reference model
// Rev    : 1.0  initial release
// ============================================================
module tb_fft_output_unloader;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_valid_in;
    logic [31:0] a_re, a_im, b_re, b_im;
    logic        i_ready;
    logic        o_valid_out;
    logic [31:0] o_data_real, o_data_imag;
    logic [9:0]  o_bin_idx;
    logic        o_last;
    logic        o_overflow;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t511 = 0;
    int first_cyc = -1;

    typedef struct {
        logic [31:0] re;
        logic [31:0] im;
        logic [9:0]  idx;
    } bin_t;

    bin_t        exp_q[$];
    logic [31:0] fr_re [3][1024];
    logic [31:0] fr_im [3][1024];

    fft_output_unloader dut (
        .i_clk(clk), .i_reset(i_reset), .i_valid_in(i_valid_in),
        .i_data_a_real(a_re), .i_data_a_imag(a_im),
        .i_data_b_real(b_re), .i_data_b_imag(b_im),
        .i_ready(i_ready), .o_valid_out(o_valid_out),
        .o_data_real(o_data_real), .o_data_imag(o_data_imag),
        .o_bin_idx(o_bin_idx), .o_last(o_last), .o_overflow(o_overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    function automatic int bitrev_tb(input int p);
        int r = 0;
        for (int i = 0; i < 9; i++) begin
            if (((p >> i) & 1) != 0) r += (1 << (8 - i));
        end
        return r;
    endfunction

    // Bin k of the frame in slot s; optionally queued as expected output.
    task automatic gen_frame(input int s, input bit rnd, input bit push);
        for (int k = 0; k < 1024; k++) begin
            fr_re[s][k] = rnd ? $urandom : 32'(k);
            fr_im[s][k] = rnd ? $urandom : -fr_re[s][k];
            if (push) exp_q.push_back('{fr_re[s][k], fr_im[s][k], 10'(k)});
        end
    endtask

    task automatic drive_frame(input int s, input int first, input int count);
        int q;
        for (int p = first; p < first + count; p++) begin
            @(posedge clk); #1;
            q = bitrev_tb(p);
            i_valid_in = 1'b1;
            a_re = fr_re[s][2*q];
            a_im = fr_im[s][2*q];
            b_re = fr_re[s][2*q+1];
            b_im = fr_im[s][2*q+1];
            if (p == 511) t511 = cyc + 1;
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            i_valid_in = 1'b0;
        end
    endtask

    task automatic collect(input int nbins, input bit rnd, input bit contig, input string name);
        int   got = 0, waited = 0, gaps = 0;
        bit   started = 0, pv = 0, pr = 0;
        logic [31:0] p_re = '0, p_im = '0;
        logic [9:0]  p_idx = '0;
        logic        p_last = 1'b0;
        bin_t e;
        while (got < nbins && waited < nbins * 4 + 2000) begin
            @(posedge clk); #1;
            i_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            waited++;
            if (pv && !pr) begin
                checks++;
                if (o_valid_out !== 1'b1 || o_data_real !== p_re || o_data_imag !== p_im ||
                    o_bin_idx !== p_idx || o_last !== p_last) begin
                    errors++;
                    $display("FAIL %s stall_hold: got v=%b re=%h idx=%0d last=%b, need v=1 re=%h idx=%0d last=%b",
                             name, o_valid_out, o_data_real, o_bin_idx, o_last, p_re, p_idx, p_last);
                end
            end
            if (o_valid_out === 1'b1) started = 1;
            else if (started && contig) gaps++;
            if (o_valid_out === 1'b1 && i_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s unexpected_bin: got idx=%0d re=%h, need no output", name, o_bin_idx, o_data_real);
                end else begin
                    e = exp_q.pop_front();
                    if (o_data_real !== e.re || o_data_imag !== e.im || o_bin_idx !== e.idx ||
                        o_last !== (e.idx == 10'd1023)) begin
                        errors++;
                        $display("FAIL %s bin: got re=%h im=%h idx=%0d last=%b, need re=%h im=%h idx=%0d last=%b",
                                 name, o_data_real, o_data_imag, o_bin_idx, o_last,
                                 e.re, e.im, e.idx, (e.idx == 10'd1023));
                    end
                end
                if (first_cyc < 0) first_cyc = cyc;
                got++;
            end
            pv = (o_valid_out === 1'b1);
            pr = i_ready;
            p_re = o_data_real; p_im = o_data_imag; p_idx = o_bin_idx; p_last = o_last;
        end
        checks++;
        if (got != nbins) begin
            errors++;
            $display("FAIL %s bin_count: got %0d bins, need %0d", name, got, nbins);
        end
        if (contig) begin
            checks++;
            if (gaps != 0) begin
                errors++;
                $display("FAIL %s contiguity: got %0d idle cycles, need 0", name, gaps);
            end
        end
    endtask

    task automatic idle_check(input int n, input string name);
        int bad = 0;
        repeat (n) begin
            @(negedge clk);
            if (o_valid_out !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s idle: got %0d valid cycles and %0d pending bins, need 0 and 0", name, bad, exp_q.size());
        end
    endtask

    task automatic test_reset();
        int bad = 0;
        i_reset = 1'b0; i_valid_in = 1'b0; i_ready = 1'b0;
        a_re = '0; a_im = '0; b_re = '0; b_im = '0;
        repeat (3) @(posedge clk);
        #1 i_reset = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (o_valid_out !== 1'b0 || o_overflow !== 1'b0 || o_data_real !== '0 ||
                o_data_imag !== '0 || o_bin_idx !== '0 || o_last !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_idle: got %0d nonzero-output cycles, need 0", bad);
        end
    endtask

    task automatic test_one_frame();
        gen_frame(0, 1'b0, 1'b1);
        first_cyc = -1;
        fork
            begin drive_frame(0, 0, 512); idle_cycles(1); end
            collect(1024, 1'b0, 1'b1, "one_frame");
        join
        checks++;
        if (first_cyc - t511 != 2) begin
            errors++;
            $display("FAIL one_frame latency: got %0d cycles, need 2", first_cyc - t511);
        end
        idle_check(20, "one_frame");
    endtask

    task automatic test_random_ready();
        gen_frame(0, 1'b1, 1'b1);
        fork
            begin drive_frame(0, 0, 512); idle_cycles(1); end
            collect(1024, 1'b1, 1'b0, "random_ready");
        join
        i_ready = 1'b1;
        idle_check(20, "random_ready");
    endtask

    task automatic test_back_to_back();
        gen_frame(0, 1'b1, 1'b1);
        gen_frame(1, 1'b1, 1'b1);
        fork
            begin
                drive_frame(0, 0, 512);
                idle_cycles(512);
                drive_frame(1, 0, 512);
                idle_cycles(1);
            end
            collect(2048, 1'b0, 1'b1, "back_to_back");
        join
        checks++;
        if (o_overflow !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back overflow: got %b, need 0", o_overflow);
        end
        idle_check(20, "back_to_back");
    endtask

    task automatic test_overflow();
        i_ready = 1'b0;
        gen_frame(0, 1'b1, 1'b1);
        gen_frame(1, 1'b1, 1'b1);
        gen_frame(2, 1'b1, 1'b0);
        drive_frame(0, 0, 512);
        drive_frame(1, 0, 512);
        drive_frame(2, 0, 1);
        checks++;
        if (o_overflow !== 1'b0) begin
            errors++;
            $display("FAIL overflow_early: got %b, need 0", o_overflow);
        end
        idle_cycles(1);
        checks++;
        if (o_overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_set: got %b, need 1", o_overflow);
        end
        checks++;
        if (o_valid_out !== 1'b1 || o_bin_idx !== 10'd0) begin
            errors++;
            $display("FAIL overflow_held_bin: got v=%b idx=%0d, need v=1 idx=0", o_valid_out, o_bin_idx);
        end
        drive_frame(2, 1, 511);
        idle_cycles(5);
        collect(2048, 1'b0, 1'b0, "overflow");
        idle_check(30, "overflow");
        checks++;
        if (o_overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_sticky: got %b, need 1", o_overflow);
        end
    endtask

    task automatic test_reset_mid_frame();
        gen_frame(0, 1'b1, 1'b0);
        drive_frame(0, 0, 300);
        @(posedge clk); #1;
        i_valid_in = 1'b0;
        i_reset = 1'b0;
        @(posedge clk); #1;
        i_reset = 1'b1;
        @(negedge clk);
        checks++;
        if (o_overflow !== 1'b0 || o_valid_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_clear: got ovf=%b v=%b, need 0 0", o_overflow, o_valid_out);
        end
        gen_frame(1, 1'b1, 1'b1);
        fork
            begin drive_frame(1, 0, 512); idle_cycles(1); end
            collect(1024, 1'b1, 1'b0, "reset_mid");
        join
        i_ready = 1'b1;
        idle_check(30, "reset_mid");
    endtask

    initial begin
        test_reset();
        test_one_frame();
        test_random_ready();
        test_back_to_back();
        test_overflow();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
